// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one sequential divider among N_REQ requesters.
// A winner's operands are latched at grant, divide-by-zero is answered locally,
// and a watchdog bounds the wait on the divider.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate, grant and latch operands
// ST_START | one-cycle div_start pulse to the divider
// ST_WAIT  | wait for div_ready, watchdog counting down
// ST_ZERO  | divisor was zero; build the error result without the divider
// ST_DONE  | rsp_valid strobe, advance the round-robin pointer
module div_arbiter #(
   parameter int N_REQ   = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] req_dividend,
   input  logic [N_REQ*W-1:0] req_divisor,
   output logic [N_REQ-1:0]   gnt,
   output logic               rsp_valid,
   output logic [2:0]         rsp_id,
   output logic [W-1:0]       rsp_quo,
   output logic [W-1:0]       rsp_rem,
   output logic               rsp_err,
   output logic               busy,
   output logic               div_start,
   output logic [W-1:0]       div_dividend,
   output logic [W-1:0]       div_divisor,
   input  logic               div_ready,
   input  logic [W-1:0]       div_quo,
   input  logic [W-1:0]       div_rem
);

   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ZERO  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [2:0]     rr_ptr;
   logic [2:0]     lat_id;
   logic [WD_W-1:0] wd_cnt;
   logic [7:0]     req_pad;
   logic [7:0]     gnt_pad;
   logic [3:0]     idx;
   logic [2:0]     sel_id;
   logic           sel_vld;
   logic           grant_ok;
   logic [W-1:0]   sel_dividend;
   logic [W-1:0]   sel_divisor;

   // Round-robin pick: scan downward so the last hit is the first set bit at/after rr_ptr.
   always_comb begin
      req_pad = 8'(req);
      idx     = '0;
      sel_id  = '0;
      sel_vld = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + 4'(k);
         if (idx >= 4'(N_REQ)) begin
            idx = idx - 4'(N_REQ);
         end
         if (req_pad[idx[2:0]]) begin
            sel_vld = 1'b1;
            sel_id  = idx[2:0];
         end
      end
   end

   // gnt depends on req combinationally, so it is also masked while rst is low.
   assign grant_ok     = (state == ST_IDLE) && rst && sel_vld;
   assign sel_dividend = req_dividend[int'(sel_id) * W +: W];
   assign sel_divisor  = req_divisor[int'(sel_id) * W +: W];

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      state_nxt = state;
      gnt_pad   = '0;
      gnt       = '0;
      div_start = 1'b0;
      rsp_valid = 1'b0;
      busy      = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (grant_ok) begin
               gnt_pad   = 8'd1 << sel_id;
               gnt       = gnt_pad[N_REQ-1:0];
               state_nxt = (sel_divisor == '0) ? ST_ZERO : ST_START;
            end
         end
         ST_START: begin
            div_start = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (div_ready || (wd_cnt == '0)) begin
               state_nxt = ST_DONE;
            end
         end
         ST_ZERO: begin
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Operand latch, watchdog, result capture and pointer update.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr       <= '0;
         lat_id       <= '0;
         wd_cnt       <= '0;
         div_dividend <= '0;
         div_divisor  <= '0;
         rsp_id       <= '0;
         rsp_quo      <= '0;
         rsp_rem      <= '0;
         rsp_err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_ok) begin
                  div_dividend <= sel_dividend;
                  div_divisor  <= sel_divisor;
                  lat_id       <= sel_id;
               end
            end
            ST_START: begin
               wd_cnt <= WD_W'(TIMEOUT - 1);
            end
            ST_WAIT: begin
               if (div_ready) begin
                  rsp_quo <= div_quo;
                  rsp_rem <= div_rem;
                  rsp_err <= 1'b0;
                  rsp_id  <= lat_id;
               end else if (wd_cnt == '0) begin
                  rsp_quo <= '1;
                  rsp_rem <= '0;
                  rsp_err <= 1'b1;
                  rsp_id  <= lat_id;
               end else begin
                  wd_cnt <= wd_cnt - 1'b1;
               end
            end
            ST_ZERO: begin
               rsp_quo <= '1;
               rsp_rem <= div_dividend;
               rsp_err <= 1'b1;
               rsp_id  <= lat_id;
            end
            ST_DONE: begin
               rr_ptr <= (lat_id == 3'(N_REQ - 1)) ? 3'd0 : lat_id + 3'd1;
               wd_cnt <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed scenarios followed by random divides, all
// results predicted from the bench's own operands and a round-robin model.
module tb_div_arbiter;

   localparam int N       = 4;
   localparam int W       = 8;
   localparam int TIMEOUT = 64;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] req_dividend = '0;
   logic [N*W-1:0] req_divisor = '0;
   logic [N-1:0]   gnt;
   logic           rsp_valid;
   logic [2:0]     rsp_id;
   logic [W-1:0]   rsp_quo;
   logic [W-1:0]   rsp_rem;
   logic           rsp_err;
   logic           busy;
   logic           div_start;
   logic [W-1:0]   div_dividend;
   logic [W-1:0]   div_divisor;
   logic           div_ready = 1'b0;
   logic [W-1:0]   div_quo = '0;
   logic [W-1:0]   div_rem = '0;

   int checks = 0;
   int errors = 0;
   int ptr = 0;

   div_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_quo(rsp_quo), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
      .busy(busy), .div_start(div_start),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_ready(div_ready), .div_quo(div_quo), .div_rem(div_rem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference arbiter: first requester at or after the pointer, wrapping.
   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // One transaction from an IDLE negedge to the IDLE negedge after DONE.
   // delay < 0 means the divider never answers.
   task automatic txn(input logic [N-1:0] rv, input logic [N*W-1:0] dvd_all,
                      input logic [N*W-1:0] dvs_all, input int delay, input bit hold_all);
      int w, start_n, done_n, starts, exp_lat;
      logic [W-1:0] a, b, eq, er;
      logic ee;
      req = rv;
      req_dividend = dvd_all;
      req_divisor = dvs_all;
      #1;
      w = pick(rv, ptr);
      a = dvd_all[w*W +: W];
      b = dvs_all[w*W +: W];
      chk("gnt", 32'(gnt), 32'(1) << w);
      chk("idle_busy", 32'(busy), 0);
      if (b == 0) begin
         exp_lat = 2; eq = '1; er = a; ee = 1'b1;
      end else if (delay < 0) begin
         exp_lat = 2 + TIMEOUT; eq = '1; er = '0; ee = 1'b1;
      end else begin
         exp_lat = 3 + delay; eq = a / b; er = a % b; ee = 1'b0;
      end
      start_n = -1; done_n = -1; starts = 0;
      for (int n = 1; n < TIMEOUT + 16; n++) begin
         @(negedge clk);
         if (n == 1 && !hold_all) req[w] = 1'b0;
         if (div_start) begin
            starts++;
            start_n = n;
            chk("div_dividend", 32'(div_dividend), 32'(a));
            chk("div_divisor", 32'(div_divisor), 32'(b));
         end
         if (rsp_valid) begin
            done_n = n;
            break;
         end
         if (start_n >= 0 && delay >= 0 && n == start_n + 1 + delay) begin
            div_ready = 1'b1;
            div_quo = (div_divisor != 0) ? div_dividend / div_divisor : '1;
            div_rem = (div_divisor != 0) ? div_dividend % div_divisor : '0;
         end else begin
            div_ready = 1'b0;
            div_quo = W'($urandom);
            div_rem = W'($urandom);
         end
      end
      div_ready = 1'b0;
      chk("latency", 32'(done_n), 32'(exp_lat));
      chk("div_start_count", 32'(starts), (b == 0) ? 0 : 1);
      chk("rsp_id", 32'(rsp_id), 32'(w));
      chk("rsp_quo", 32'(rsp_quo), 32'(eq));
      chk("rsp_rem", 32'(rsp_rem), 32'(er));
      chk("rsp_err", 32'(rsp_err), 32'(ee));
      ptr = (w + 1) % N;
      @(negedge clk);
      chk("rsp_valid_pulse", 32'(rsp_valid), 0);
      chk("back_idle", 32'(busy), 0);
      chk("rsp_hold", 32'({rsp_err, rsp_quo, rsp_rem}), 32'({ee, eq, er}));
   endtask

   initial begin
      logic [N*W-1:0] dvd, dvs;
      int exp_order[5] = '{0, 1, 2, 3, 0};

      // Reset with every requester asserted: nothing may leak out.
      req = '1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_outs", 32'({rsp_valid, div_start, rsp_err, rsp_id}), 0);
      chk("rst_data", {rsp_quo, rsp_rem, div_dividend, div_divisor}, 0);
      req = '0;
      rst = 1'b1;
      @(negedge clk);
      ptr = 0;

      // 200 / 7 on requester 0, divider answers late.
      txn(4'b0001, {8'd0, 8'd0, 8'd0, 8'd200}, {8'd0, 8'd0, 8'd0, 8'd7}, 10, 1'b0);
      chk("ex1_quo", 32'(rsp_quo), 28);
      chk("ex1_rem", 32'(rsp_rem), 4);

      // Divide-by-zero on requester 1.
      txn(4'b0010, {8'd0, 8'd0, 8'd55, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 1'b0);
      chk("ex2_quo", 32'(rsp_quo), 255);

      // Divider never answers: watchdog expiry.
      txn(4'b0100, {8'd0, 8'd99, 8'd0, 8'd0}, {8'd0, 8'd5, 8'd0, 8'd0}, -1, 1'b0);

      // Reset while waiting on the divider.
      req = 4'b1000;
      req_dividend = {8'd9, 24'd0};
      req_divisor = {8'd3, 24'd0};
      #1;
      chk("mid_gnt", 32'(gnt), 32'(4'b1000));
      @(negedge clk);
      req = '0;
      repeat (2) @(negedge clk);
      chk("mid_in_wait", 32'(busy), 1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_outs", 32'({gnt, rsp_valid, div_start, rsp_err, rsp_id}), 0);
      chk("mid_rst_data", {rsp_quo, rsp_rem, div_dividend, div_divisor}, 0);
      rst = 1'b1;
      ptr = 0;
      div_ready = 1'b1;
      div_quo = 8'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late_ready_ignored", 32'({rsp_valid, busy}), 0);
      end
      div_ready = 1'b0;

      // All requesters held: rotation 0,1,2,3,0.
      for (int t = 0; t < 5; t++) begin
         chk("rr_order", 32'(pick(4'b1111, ptr)), 32'(exp_order[t]));
         txn(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd3, 8'd4, 8'd6, 8'd7}, t % 3, 1'b1);
      end
      req = '0;
      @(negedge clk);

      // Random operands on random requesters.
      for (int t = 0; t < 10000; t++) begin
         for (int i = 0; i < N; i++) begin
            dvd[i*W +: W] = W'($urandom);
            dvs[i*W +: W] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         end
         txn(N'($urandom_range(1, 15)), dvd, dvs, $urandom_range(0, 3), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, the number of requesters (2..8).
REQ-002 The block SHALL have parameter W, default 8, the operand and result width.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, the maximum cycles to wait for div_ready.
REQ-004 Port clk  input  1  single clock, all logic on rising edge.
REQ-005 Port rst  input  1  synchronous, active-low reset.
REQ-006 Port req  input  N_REQ  per-requester divide request, level, held until granted.
REQ-007 Port req_dividend  input  N_REQ*W  packed dividends, slice i belongs to requester i.
REQ-008 Port req_divisor  input  N_REQ*W  packed divisors, slice i belongs to requester i.
REQ-009 Port gnt  output  N_REQ  one-hot, one-cycle acceptance pulse.
REQ-010 Port rsp_valid  output  1  one-cycle result strobe.
REQ-011 Port rsp_id  output  3  index of the requester owning the result.
REQ-012 Port rsp_quo  output  W  quotient.
REQ-013 Port rsp_rem  output  W  remainder.
REQ-014 Port rsp_err  output  1  result invalid (divide-by-zero or timeout).
REQ-015 Port busy  output  1  high in every state except IDLE.
REQ-016 Port div_start  output  1  start pulse to the shared sequential divider.
REQ-017 Port div_dividend  output  W  dividend to the divider.
REQ-018 Port div_divisor  output  W  divisor to the divider.
REQ-019 Port div_ready  input  1  divider completion.
REQ-020 Port div_quo  input  W  divider quotient.
REQ-021 Port div_rem  input  W  divider remainder.

Function
REQ-022 The FSM SHALL have states IDLE, START, WAIT, ZERO and DONE.
REQ-023 IDLE, any req set: pick the first set bit at or after rr_ptr (wrapping modulo N_REQ), pulse gnt[i] for that cycle, and latch slice i into div_dividend/div_divisor plus the id.
REQ-024 On that grant, the next state SHALL be ZERO if the latched divisor is 0, else START.
REQ-025 START: div_start=1 for exactly one cycle, then go to WAIT.
REQ-026 div_dividend/div_divisor SHALL stay constant from grant until leaving WAIT.
REQ-027 WAIT: div_ready sampled high SHALL capture div_quo/div_rem with rsp_err=0 and go to DONE; div_ready is ignored in the START cycle.
REQ-028 WAIT: a watchdog counter reaching TIMEOUT SHALL go to DONE with rsp_err=1, rsp_quo=all-ones, rsp_rem=0.
REQ-029 ZERO: one cycle, then DONE with rsp_err=1, rsp_quo=all-ones, rsp_rem=latched dividend; div_start SHALL NOT assert.
REQ-030 DONE: rsp_valid=1 for one cycle with rsp_id/rsp_quo/rsp_rem/rsp_err valid, rr_ptr=(id+1) mod N_REQ, then go to IDLE.
REQ-031 rsp_quo/rsp_rem/rsp_err/rsp_id SHALL hold their values until the next DONE.
REQ-032 Latency grant-to-rsp_valid: 2 cycles for divide-by-zero; 3+k for a normal divide, where k = cycles from START exit to div_ready high.
REQ-033 At most one gnt bit SHALL be high, and only in IDLE; requests arriving while busy wait.
REQ-034 Dropping req before gnt SHALL be legal and SHALL cause no grant.
REQ-035 A req held through DONE SHALL be re-arbitrated in the following IDLE cycle; the round-robin pointer prevents starvation.
REQ-036 Requester indices >= N_REQ SHALL never be granted.

Reset
REQ-037 rst low at a clock edge SHALL force IDLE, rr_ptr=0, watchdog=0, and all outputs 0, including div_start and gnt.
REQ-038 Reset mid-operation SHALL abandon the transaction with no rsp_valid; a later div_ready in IDLE SHALL be ignored.

Verification
REQ-039 req=0001, dividend 200, divisor 7, divider ready after 10 cycles -> gnt=0001, one div_start, rsp_valid with id 0, quo 28, rem 4, err 0.
REQ-040 req=0010, divisor 0, dividend 55 -> no div_start, rsp_valid 2 cycles after gnt, quo 255, rem 55, err 1.
REQ-041 req=1111 held continuously -> grant order 0,1,2,3,0 with exactly one gnt bit per transaction.
REQ-042 div_ready held low -> rsp_valid with err 1 and quo 255 after TIMEOUT WAIT cycles; FSM returns to IDLE.
REQ-043 rst low during WAIT -> next cycle busy=0 and all outputs 0; a subsequent div_ready produces no rsp_valid.
REQ-044 10000 random operand pairs on random requesters, compared against a reference model -> quo/rem match for nonzero divisors, err set exactly when divisor is 0.
